// File: rtl/ssd_scan_driver_if.sv
// ssd_scan_driver_if
//   Bundles the display-data inputs and the pin-side outputs of ssd_scan_driver.
//   Signals:
//     DigitData  4*NUM_DIGITS  nibble i = DigitData[4i+3:4i]
//     DigitEn    NUM_DIGITS    1 = digit i lit
//     DpEn       NUM_DIGITS    1 = decimal point of digit i lit
//     BlinkMask  NUM_DIGITS    1 = digit i blinks
//     An         NUM_DIGITS    anodes, active-low
//     Cathodes   7             {Ca..Cg}, active-low
//     Dp         1             decimal point cathode, active-low
//     FrameDone  1             one-cycle pulse after each completed frame
//   Transfer semantics: there is no valid/ready pair. The data inputs are level
//   signals that the driver samples only on the end-of-frame edge; FrameDone
//   tells the producer that a sample has just been taken, so it may update
//   freely at any time and the change is shown from the next frame on.
//   Modports: master = producer/observer (core logic), slave = the driver.
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] DigitData;
  logic [NUM_DIGITS-1:0]   DigitEn;
  logic [NUM_DIGITS-1:0]   DpEn;
  logic [NUM_DIGITS-1:0]   BlinkMask;
  logic [NUM_DIGITS-1:0]   An;
  logic [6:0]              Cathodes;
  logic                    Dp;
  logic                    FrameDone;

  modport master (
    output DigitData, DigitEn, DpEn, BlinkMask,
    input  An, Cathodes, Dp, FrameDone
  );

  modport slave (
    input  DigitData, DigitEn, DpEn, BlinkMask,
    output An, Cathodes, Dp, FrameDone
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Time-multiplexed seven-segment scan driver. Each digit owns a slot of
//   SCAN_DIV clocks; the first BLANK_CYCLES of every slot keep all anodes off
//   to avoid ghosting. Display data is captured into shadow registers only at
//   the end of a frame so a frame is never torn. Blink phase toggles every
//   BLINK_FRAMES frames.
//   Ports:
//     ClkPort  in  system clock, rising edge
//     Reset_n  in  asynchronous active-low reset
//     bus      slave modport of ssd_scan_driver_if (data in, pins out)
module ssd_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 65536,
  parameter int BLANK_CYCLES = 1024,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                ClkPort,
  input  logic                Reset_n,
  ssd_scan_driver_if.slave    bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_MAX   = FRM_W'(BLINK_FRAMES - 1);

  // Scan position and frame/blink bookkeeping
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [FRM_W-1:0]        r_frm;
  logic                    r_phase;

  // Shadow copies of the inputs, refreshed once per frame
  logic [4*NUM_DIGITS-1:0] r_sh_data;
  logic [NUM_DIGITS-1:0]   r_sh_en;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blink;

  // Registered pin drivers
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_cath;
  logic                    r_dp;
  logic                    r_frame_done;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic                    w_blank;
  logic                    w_visible;
  logic [3:0]              w_nibble;
  logic [NUM_DIGITS-1:0]   w_an_sel;

  // Active-low segment patterns {a,b,c,d,e,f,g} for hex 0..F
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign w_slot_end  = (r_cnt == CNT_MAX);
  assign w_frame_end = w_slot_end && (r_idx == IDX_MAX);
  assign w_blank     = (r_cnt < CNT_BLANK);
  assign w_nibble    = r_sh_data[{r_idx, 2'b00} +: 4];
  // A blinking digit is hidden during the "off" half of the blink period.
  assign w_visible   = r_sh_en[r_idx] && !(r_sh_blink[r_idx] && r_phase);
  assign w_an_sel    = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx);

  // Scan counters, shadow capture and blink phase
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_frm      <= '0;
      r_phase    <= 1'b0;
      r_sh_data  <= '0;
      r_sh_en    <= '0;
      r_sh_dp    <= '0;
      r_sh_blink <= '0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      if (w_slot_end) begin
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end
      if (w_frame_end) begin
        r_sh_data  <= bus.DigitData;
        r_sh_en    <= bus.DigitEn;
        r_sh_dp    <= bus.DpEn;
        r_sh_blink <= bus.BlinkMask;
        if (r_frm == FRM_MAX) begin
          r_frm   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frm <= r_frm + 1'b1;
        end
      end
    end
  end

  // Output stage: everything is computed from the current scan state and
  // shadow registers, then registered, so pins change one clock later.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      r_an         <= '1;
      r_cath       <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_blank) begin
        r_an   <= '1;
        r_cath <= 7'h7F;
        r_dp   <= 1'b1;
      end else begin
        r_an   <= w_an_sel;
        r_cath <= w_visible ? glyph(w_nibble) : 7'h7F;
        r_dp   <= ~(r_sh_dp[r_idx] && w_visible);
      end
    end
  end

  assign bus.An        = r_an;
  assign bus.Cathodes  = r_cath;
  assign bus.Dp        = r_dp;
  assign bus.FrameDone = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver
//   Directed bench for ssd_scan_driver with NUM_DIGITS=4, SCAN_DIV=8,
//   BLANK_CYCLES=2, BLINK_FRAMES=2. The bench counts clock edges since reset
//   release (k); edge k handles scan position cnt=(k-1)%8, digit=((k-1)/8)%4,
//   frame=(k-1)/32, and the outputs sampled 1 ns after edge k reflect it.
module tb_ssd_scan_driver;

  localparam int ND = 4;

  logic clk;
  logic rst_n;
  int   k;
  int   n_pass;
  int   n_total;

  ssd_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  ssd_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2)
  ) dut (
    .ClkPort(clk),
    .Reset_n(rst_n),
    .bus    (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- expected-value helpers ----------------
  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b0000001;  4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;  4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;  4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;  4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;  4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;  default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] exp_an(input int kk);
    int c, i;
    logic [3:0] one;
    c = (kk - 1) % 8;
    i = ((kk - 1) / 8) % 4;
    one = 4'b0001 << i;
    return (c < 2) ? 4'hF : ~one;
  endfunction

  function automatic logic [6:0] exp_cath(input int kk, input logic [15:0] d,
                                          input logic [3:0] en, input logic [3:0] bl,
                                          input logic ph);
    int c, i;
    c = (kk - 1) % 8;
    i = ((kk - 1) / 8) % 4;
    if (c < 2) return 7'h7F;
    if (en[i] && !(bl[i] && ph)) return glyph_of(d[i*4 +: 4]);
    return 7'h7F;
  endfunction

  function automatic logic exp_dp(input int kk, input logic [3:0] dp,
                                  input logic [3:0] en, input logic [3:0] bl,
                                  input logic ph);
    int c, i;
    c = (kk - 1) % 8;
    i = ((kk - 1) / 8) % 4;
    if (c < 2) return 1'b1;
    return !(dp[i] && en[i] && !(bl[i] && ph));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] en,
                       input logic [3:0] dp, input logic [3:0] bl);
    bus.DigitData = d;
    bus.DigitEn   = en;
    bus.DpEn      = dp;
    bus.BlinkMask = bl;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(16'h3A1F, 4'hF, 4'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.An !== 4'hF) $display("FAIL reset_an got %b want 1111", bus.An); else n_pass++;
    n_total++; if (bus.Cathodes !== 7'h7F) $display("FAIL reset_cath got %b want 1111111", bus.Cathodes); else n_pass++;
    n_total++; if (bus.Dp !== 1'b1) $display("FAIL reset_dp got %b want 1", bus.Dp); else n_pass++;
    n_total++; if (bus.FrameDone !== 1'b0) $display("FAIL reset_fd got %b want 0", bus.FrameDone); else n_pass++;
    rst_n = 1'b1;
    k = 0;
  endtask

  // Frame 0 after reset: shadow registers are zero, nothing is lit.
  task automatic test_first_frame();
    int fd_seen;
    fd_seen = 0;
    for (int j = 0; j < 32; j++) begin
      step();
      if (bus.FrameDone === 1'b1) fd_seen++;
      n_total++; if (bus.Cathodes !== 7'h7F) $display("FAIL f0_cath k=%0d got %b want 1111111", k, bus.Cathodes); else n_pass++;
      n_total++; if (bus.Dp !== 1'b1) $display("FAIL f0_dp k=%0d got %b want 1", k, bus.Dp); else n_pass++;
      n_total++; if (bus.FrameDone !== (j == 31)) $display("FAIL f0_fd k=%0d got %b want %b", k, bus.FrameDone, (j == 31)); else n_pass++;
    end
    n_total++; if (fd_seen !== 1) $display("FAIL f0_fd_count got %0d want 1", fd_seen); else n_pass++;
  endtask

  // Frame 1: 3A1F scanned as F,1,A,3; a mid-frame data change must not show.
  task automatic test_scan();
    for (int j = 0; j < 32; j++) begin
      if (j == 8) bus.DigitData = 16'h0000;
      step();
      n_total++; if (bus.An !== exp_an(k)) $display("FAIL scan_an k=%0d got %b want %b", k, bus.An, exp_an(k)); else n_pass++;
      n_total++; if (bus.Cathodes !== exp_cath(k, 16'h3A1F, 4'hF, 4'h0, 1'b0)) $display("FAIL scan_cath k=%0d got %b want %b", k, bus.Cathodes, exp_cath(k, 16'h3A1F, 4'hF, 4'h0, 1'b0)); else n_pass++;
      n_total++; if (bus.Dp !== 1'b1) $display("FAIL scan_dp k=%0d got %b want 1", k, bus.Dp); else n_pass++;
      n_total++; if (bus.FrameDone !== (j == 31)) $display("FAIL scan_fd k=%0d got %b want %b", k, bus.FrameDone, (j == 31)); else n_pass++;
    end
  endtask

  // Frame 2: the zero data captured at the end of frame 1 shows on all digits.
  task automatic test_data_update();
    for (int j = 0; j < 32; j++) begin
      if (j == 5) drive(16'h8421, 4'b0101, 4'b0001, 4'h0);
      step();
      n_total++; if (bus.An !== exp_an(k)) $display("FAIL upd_an k=%0d got %b want %b", k, bus.An, exp_an(k)); else n_pass++;
      n_total++; if (bus.Cathodes !== exp_cath(k, 16'h0000, 4'hF, 4'h0, 1'b1)) $display("FAIL upd_cath k=%0d got %b want %b", k, bus.Cathodes, exp_cath(k, 16'h0000, 4'hF, 4'h0, 1'b1)); else n_pass++;
      n_total++; if (bus.Dp !== 1'b1) $display("FAIL upd_dp k=%0d got %b want 1", k, bus.Dp); else n_pass++;
    end
  endtask

  // Frame 3: digits 1,3 disabled; decimal point only on digit 0.
  task automatic test_enable_dp();
    for (int j = 0; j < 32; j++) begin
      if (j == 3) drive(16'h3A1F, 4'hF, 4'h0, 4'b0010);
      step();
      n_total++; if (bus.An !== exp_an(k)) $display("FAIL en_an k=%0d got %b want %b", k, bus.An, exp_an(k)); else n_pass++;
      n_total++; if (bus.Cathodes !== exp_cath(k, 16'h8421, 4'b0101, 4'h0, 1'b1)) $display("FAIL en_cath k=%0d got %b want %b", k, bus.Cathodes, exp_cath(k, 16'h8421, 4'b0101, 4'h0, 1'b1)); else n_pass++;
      n_total++; if (bus.Dp !== exp_dp(k, 4'b0001, 4'b0101, 4'h0, 1'b1)) $display("FAIL en_dp k=%0d got %b want %b", k, bus.Dp, exp_dp(k, 4'b0001, 4'b0101, 4'h0, 1'b1)); else n_pass++;
    end
  endtask

  // Frames 4..7: digit 1 lit in frames 4,5 and blank in frames 6,7.
  task automatic test_blink();
    logic ph;
    int lit1;
    for (int f = 4; f < 8; f++) begin
      ph = ((f / 2) % 2) == 1;
      lit1 = 0;
      for (int j = 0; j < 32; j++) begin
        step();
        if (bus.An === 4'b1101 && bus.Cathodes === 7'b1001111) lit1++;
        n_total++; if (bus.An !== exp_an(k)) $display("FAIL blink_an k=%0d got %b want %b", k, bus.An, exp_an(k)); else n_pass++;
        n_total++; if (bus.Cathodes !== exp_cath(k, 16'h3A1F, 4'hF, 4'b0010, ph)) $display("FAIL blink_cath k=%0d got %b want %b", k, bus.Cathodes, exp_cath(k, 16'h3A1F, 4'hF, 4'b0010, ph)); else n_pass++;
      end
      n_total++; if (lit1 !== (ph ? 0 : 6)) $display("FAIL blink_lit_cycles frame=%0d got %0d want %0d", f, lit1, (ph ? 0 : 6)); else n_pass++;
    end
  endtask

  // Frame 8: reset asserted during digit 2's active window.
  task automatic test_reset_mid();
    for (int j = 0; j < 20; j++) step();
    n_total++; if (bus.An !== 4'b1011) $display("FAIL mid_pre_an got %b want 1011", bus.An); else n_pass++;
    n_total++; if (bus.Cathodes !== 7'b0001000) $display("FAIL mid_pre_cath got %b want 0001000", bus.Cathodes); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.An !== 4'hF) $display("FAIL mid_async_an got %b want 1111", bus.An); else n_pass++;
    n_total++; if (bus.Cathodes !== 7'h7F) $display("FAIL mid_async_cath got %b want 1111111", bus.Cathodes); else n_pass++;
    n_total++; if (bus.Dp !== 1'b1) $display("FAIL mid_async_dp got %b want 1", bus.Dp); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    for (int j = 0; j < 32; j++) begin
      step();
      n_total++; if (bus.Cathodes !== 7'h7F) $display("FAIL rst_f0_cath k=%0d got %b want 1111111", k, bus.Cathodes); else n_pass++;
      n_total++; if (bus.FrameDone !== (j == 31)) $display("FAIL rst_f0_fd k=%0d got %b want %b", k, bus.FrameDone, (j == 31)); else n_pass++;
    end
    // Blink phase restarts at 0, so digit 1 is lit again in frame 1.
    for (int j = 0; j < 32; j++) begin
      step();
      n_total++; if (bus.An !== exp_an(k)) $display("FAIL rst_f1_an k=%0d got %b want %b", k, bus.An, exp_an(k)); else n_pass++;
      n_total++; if (bus.Cathodes !== exp_cath(k, 16'h3A1F, 4'hF, 4'b0010, 1'b0)) $display("FAIL rst_f1_cath k=%0d got %b want %b", k, bus.Cathodes, exp_cath(k, 16'h3A1F, 4'hF, 4'b0010, 1'b0)); else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_pass  = 0;
    n_total = 0;
    k       = 0;
    rst_n   = 1'b0;
    drive(16'h0000, 4'h0, 4'h0, 4'h0);
    test_reset();
    test_first_frame();
    test_scan();
    test_data_update();
    test_enable_dp();
    test_blink();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
